// File: rtl/irq_controller_pkg.sv
// irq_ctrl_pkg: shared constants for the interrupt controller.
//   Register word indexes, ACTIVE layout and per-channel mode encodings.
package irq_ctrl_pkg;
   localparam int REG_PENDING = 0;
   localparam int REG_MASK    = 1;
   localparam int REG_MODE    = 2;
   localparam int REG_RAW     = 3;
   localparam int REG_ACTIVE  = 4;
   localparam int REG_STATS   = 5;

   localparam int ACTIVE_VALID_BIT = 31;

   localparam logic MODE_EDGE  = 1'b1;
   localparam logic MODE_LEVEL = 1'b0;
endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: start/done register access port.
//   start : one-cycle access request       addr : register word index
//   data  : write data                     we   : write enable (with start)
//   q     : read data, valid while done    done : one-cycle completion pulse
interface irq_controller_if #(
   parameter int ADDR_BITS = 3
) ();
   logic                 start;
   logic [ADDR_BITS-1:0] addr;
   logic [31:0]          data;
   logic                 we;
   logic [31:0]          q;
   logic                 done;

   modport master (output start, addr, data, we, input q, done);
   modport slave  (input start, addr, data, we, output q, done);
endinterface

// File: rtl/irq_controller_sync_edge.sv
// irq_sync_edge: one interrupt channel front end.
//   clk, reset : clock, synchronous active-high reset
//   irq        : asynchronous raw source
//   mode       : 1 = rising edge, 0 = level
//   s          : synchronised level (last stage of the chain)
//   set        : registered set condition for the pending latch
module irq_sync_edge
   import irq_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   input  logic mode,
   output logic s,
   output logic set
);
   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   assign s = chain[SYNC_STAGES-1];

   // set is registered so the pending latch sees a clean one-flop boundary;
   // this is the extra cycle in the SYNC_STAGES + 1 latency.
   always_ff @(posedge clk) begin
      if (reset) begin
         chain <= '0;
         prev  <= 1'b0;
         set   <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], irq};
         prev  <= s;
         set   <= (mode == MODE_EDGE) ? (s & ~prev) : s;
      end
   end
endmodule

// File: rtl/irq_controller.sv
// irq_controller: NUM_IRQ-channel interrupt aggregator with a start/done
// register port.
//   clk, reset : clock, synchronous active-high reset
//   irq_in     : asynchronous raw interrupt sources
//   bus        : register port (irq_controller_if.slave)
//   cpu_irq    : one-cycle pulse when a channel becomes pending & unmasked
//   irq_any    : registered OR of pending & mask
// Build option: define IRQ_CTRL_STATS_EN for per-channel 8-bit saturating
// event counters at register 5; without it register 5 reads 0.
// An access sampled at edge t returns q/done in the following cycle and its
// write is applied at edge t+1.
module irq_controller
   import irq_ctrl_pkg::*;
#(
   parameter int                 NUM_IRQ     = 8,
   parameter int                 SYNC_STAGES = 2,
   parameter int                 ADDR_BITS   = 3,
   parameter logic [NUM_IRQ-1:0] RESET_MASK  = '1,
   parameter logic [NUM_IRQ-1:0] RESET_MODE  = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   irq_controller_if.slave    bus,
   output logic [NUM_IRQ-1:0] cpu_irq,
   output logic               irq_any
);
   logic [NUM_IRQ-1:0]   raw, set_vec;
   logic [NUM_IRQ-1:0]   pending, pend_nxt, mask, mode, en, en_q, clr;
   logic                 req_vld, req_we;
   logic [ADDR_BITS-1:0] req_addr;
   logic [31:0]          req_data;
   logic                 wr;
   logic                 act_hit;
   logic [4:0]           act_idx;
   logic [7:0]           stats_rd;
   logic [31:0]          rdata;
   logic                 unused_bits;

   assign unused_bits = ^req_data;

   for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
      irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
         .clk  (clk),
         .reset(reset),
         .irq  (irq_in[i]),
         .mode (mode[i]),
         .s    (raw[i]),
         .set  (set_vec[i])
      );
   end

   assign wr = req_vld & req_we;
   assign en = pending & mask;

   // W1C and set on the same bit: set wins.
   always_comb begin
      clr = '0;
      if (wr && int'(req_addr) == REG_PENDING) clr = req_data[NUM_IRQ-1:0];
      pend_nxt = (pending & ~clr) | set_vec;
   end

   // Lowest index wins: scan downward so the last hit is the smallest.
   always_comb begin
      act_hit = 1'b0;
      act_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (en[i]) begin
            act_hit = 1'b1;
            act_idx = 5'(i);
         end
      end
   end

`ifdef IRQ_CTRL_STATS_EN
   logic [NUM_IRQ-1:0][7:0] cnt;
   logic [NUM_IRQ-1:0]      inc;
   logic [4:0]              data_sel;
   logic                    wr_stats;

   // Edge channels count set events; level channels count pending 0->1.
   assign inc      = (mode & set_vec) | (~mode & pend_nxt & ~pending);
   assign wr_stats = wr && int'(req_addr) == REG_STATS;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         data_sel <= '0;
      end else begin
         if (wr_stats) data_sel <= req_data[4:0];
         for (int i = 0; i < NUM_IRQ; i++) begin
            if (wr_stats && req_data[31])          cnt[i] <= '0;
            else if (inc[i] && cnt[i] != 8'hFF)    cnt[i] <= cnt[i] + 8'd1;
         end
      end
   end

   // Selector may exceed NUM_IRQ; such channels read 0.
   always_comb begin
      stats_rd = '0;
      for (int i = 0; i < NUM_IRQ; i++)
         if (5'(i) == data_sel) stats_rd = cnt[i];
   end
`else
   assign stats_rd = '0;
`endif

   always_comb begin
      rdata = '0;
      case (int'(bus.addr))
         REG_PENDING: rdata = 32'(pending);
         REG_MASK:    rdata = 32'(mask);
         REG_MODE:    rdata = 32'(mode);
         REG_RAW:     rdata = 32'(raw);
         REG_ACTIVE: begin
            rdata[ACTIVE_VALID_BIT] = act_hit;
            rdata[4:0]              = act_idx;
         end
         REG_STATS:   rdata = {24'd0, stats_rd};
         default:     rdata = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending  <= '0;
         mask     <= RESET_MASK;
         mode     <= RESET_MODE;
         en_q     <= '0;
         cpu_irq  <= '0;
         irq_any  <= 1'b0;
         req_vld  <= 1'b0;
         req_we   <= 1'b0;
         req_addr <= '0;
         req_data <= '0;
         bus.q    <= '0;
         bus.done <= 1'b0;
      end else begin
         req_vld  <= bus.start;
         req_we   <= bus.we;
         req_addr <= bus.addr;
         req_data <= bus.data;
         // q returns the addressed register for reads and writes alike.
         bus.done <= bus.start;
         bus.q    <= bus.start ? rdata : '0;

         pending <= pend_nxt;
         if (wr && int'(req_addr) == REG_MASK) mask <= req_data[NUM_IRQ-1:0];
         if (wr && int'(req_addr) == REG_MODE) mode <= req_data[NUM_IRQ-1:0];

         // Pulse on newly enabled channels, including unmask of a pending one.
         en_q    <= en;
         cpu_irq <= en & ~en_q;
         irq_any <= |en;
      end
   end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: randomized + directed bench with a reference model.
// The model tracks sampled input history and applies the documented
// latencies; expected reads and cpu_irq pulses go into queues that an
// independent negedge monitor drains and compares.
module tb_irq_controller;
   import irq_ctrl_pkg::*;

   localparam int N  = 8;
   localparam int S  = 2;
   localparam int AB = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] irq_in = '0;
   logic [N-1:0] cpu_irq;
   logic         irq_any;

   irq_controller_if #(.ADDR_BITS(AB)) bus ();

   irq_controller #(
      .NUM_IRQ(N), .SYNC_STAGES(S), .ADDR_BITS(AB),
      .RESET_MASK({N{1'b1}}), .RESET_MODE({N{1'b1}})
   ) dut (
      .clk(clk), .reset(reset), .irq_in(irq_in), .bus(bus),
      .cpu_irq(cpu_irq), .irq_any(irq_any)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; logic [31:0] val; } exp_t;
   exp_t rd_q[$];
   exp_t cpu_q[$];

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   logic [N-1:0] xh [64];   // irq_in sampled at each edge
   logic [N-1:0] mh [64];   // mode register value in force at each edge
   logic [N-1:0] m_pend, m_mask, m_mode, m_en_prev;
   logic         m_any;
   logic [7:0]   m_cnt [N];
   logic [4:0]   m_sel;
   logic         w_pend;
   logic [AB-1:0] w_addr;
   logic [31:0]  w_data;
   int           m_n = 0;

   function automatic int rix(int j);
      return ((j % 64) + 64) % 64;
   endfunction

   function automatic logic [31:0] model_read(int a);
      logic [N-1:0] e;
      case (a)
         0: return 32'(m_pend);
         1: return 32'(m_mask);
         2: return 32'(m_mode);
         3: return 32'(xh[rix(m_n - S + 1)]);
         4: begin
            e = m_pend & m_mask;
            for (int i = 0; i < N; i++)
               if (e[i]) return 32'h8000_0000 | 32'(i);
            return 32'd0;
         end
`ifdef IRQ_CTRL_STATS_EN
         5: return (int'(m_sel) < N) ? {24'd0, m_cnt[m_sel]} : 32'd0;
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_edge(input logic r, input logic st, input logic [AB-1:0] a,
                             input logic [31:0] d, input logic w, input logic [N-1:0] x);
      logic [N-1:0] setv, cur, prv, mo, clr, newp, e, pulse;
      exp_t ent;
      m_n++;
      if (r) begin
         for (int j = 0; j < 64; j++) begin xh[j] = '0; mh[j] = '0; end
         m_pend = '0; m_mask = '1; m_mode = '1; m_en_prev = '0; m_any = 1'b0;
         for (int i = 0; i < N; i++) m_cnt[i] = 8'd0;
         m_sel = '0; w_pend = 1'b0;
         return;
      end
      xh[rix(m_n)] = x;
      mh[rix(m_n)] = m_mode;
      // Value sampled at edge n-S-1 reaches pending at edge n.
      cur = xh[rix(m_n - S - 1)];
      prv = xh[rix(m_n - S - 2)];
      mo  = mh[rix(m_n - 1)];
      for (int i = 0; i < N; i++) setv[i] = mo[i] ? (cur[i] & ~prv[i]) : cur[i];
      clr  = (w_pend && int'(w_addr) == 0) ? w_data[N-1:0] : '0;
      newp = (m_pend & ~clr) | setv;
`ifdef IRQ_CTRL_STATS_EN
      for (int i = 0; i < N; i++) begin
         logic hit;
         hit = m_mode[i] ? setv[i] : (newp[i] & ~m_pend[i]);
         if (w_pend && int'(w_addr) == 5 && w_data[31]) m_cnt[i] = 8'd0;
         else if (hit && m_cnt[i] != 8'd255)            m_cnt[i] = m_cnt[i] + 8'd1;
      end
      if (w_pend && int'(w_addr) == 5) m_sel = w_data[4:0];
`endif
      e     = m_pend & m_mask;
      pulse = e & ~m_en_prev;
      if (pulse != '0) begin ent.cyc = m_n; ent.val = 32'(pulse); cpu_q.push_back(ent); end
      m_en_prev = e;
      m_any     = |e;
      if (w_pend && int'(w_addr) == 1) m_mask = w_data[N-1:0];
      if (w_pend && int'(w_addr) == 2) m_mode = w_data[N-1:0];
      m_pend = newp;
      w_pend = st & w;
      w_addr = a;
      w_data = d;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      logic r, st, w;
      logic [AB-1:0] a;
      logic [31:0] d;
      logic [N-1:0] x;
      exp_t ent;
      r = reset; st = bus.start; w = bus.we; a = bus.addr; d = bus.data; x = irq_in;
      if (st && !r) begin
         ent.cyc = m_n + 1;
         ent.val = model_read(int'(a));
         rd_q.push_back(ent);
      end
      @(posedge clk);
      #1;
      model_edge(r, st, a, d, w, x);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic access(input int a, input logic [31:0] d, input logic w);
      bus.start = 1'b1; bus.addr = AB'(a); bus.data = d; bus.we = w;
      tick();
      bus.start = 1'b0; bus.we = 1'b0;
      tick();
   endtask

   task automatic burst_read(input int a, input int n);
      for (int k = 0; k < n; k++) begin
         bus.start = 1'b1; bus.addr = AB'(a); bus.we = 1'b0;
         tick();
      end
      bus.start = 1'b0;
      tick();
   endtask

   task automatic chk_any(input string nm);
      checks++;
      if (irq_any !== m_any) begin
         errors++;
         $display("FAIL %s irq_any got %b want %b", nm, irq_any, m_any);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected cyc %0d q %h", m_n, bus.q);
         end else begin
            e = rd_q.pop_front();
            if (e.cyc != m_n || bus.q !== e.val) begin
               errors++;
               $display("FAIL read cyc %0d q %h want %h at cyc %0d", m_n, bus.q, e.val, e.cyc);
            end
         end
      end else if (rd_q.size() > 0 && rd_q[0].cyc <= m_n) begin
         checks++; errors++;
         e = rd_q.pop_front();
         $display("FAIL done_missing cyc %0d want q %h", m_n, e.val);
      end
      if (cpu_irq !== '0) begin
         checks++;
         if (cpu_q.size() == 0) begin
            errors++;
            $display("FAIL cpu_irq_unexpected cyc %0d got %h", m_n, cpu_irq);
         end else begin
            e = cpu_q.pop_front();
            if (e.cyc != m_n || 32'(cpu_irq) !== e.val) begin
               errors++;
               $display("FAIL cpu_irq cyc %0d got %h want %h at cyc %0d", m_n, cpu_irq, e.val, e.cyc);
            end
         end
      end else if (cpu_q.size() > 0 && cpu_q[0].cyc <= m_n) begin
         checks++; errors++;
         e = cpu_q.pop_front();
         $display("FAIL cpu_irq_missing cyc %0d want %h", m_n, e.val);
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      bus.start = 1'b0; bus.addr = '0; bus.data = '0; bus.we = 1'b0;
      reset = 1'b1;
      idle(3);
      reset = 1'b0;

      // reset values
      for (int a = 0; a < 6; a++) access(a, 32'd0, 1'b0);
      chk_any("reset");

      // edge on channel 3: exact latency via back-to-back reads
      irq_in[3] = 1'b1;
      burst_read(0, 6);
      access(4, 32'd0, 1'b0);
      chk_any("ch3_set");
      access(0, 32'h08, 1'b1);
      idle(2);
      access(0, 32'd0, 1'b0);
      chk_any("ch3_clr");
      irq_in[3] = 1'b0;
      idle(4);

      // priority and masking
      irq_in[1] = 1'b1; irq_in[5] = 1'b1;
      idle(5);
      access(4, 32'd0, 1'b0);
      access(1, 32'hFD, 1'b1);
      access(4, 32'd0, 1'b0);
      access(1, 32'hFF, 1'b1);
      idle(3);
      access(0, 32'h22, 1'b1);
      irq_in[1] = 1'b0; irq_in[5] = 1'b0;
      idle(4);
      access(0, 32'd0, 1'b0);

      // level mode on channel 2
      access(2, 32'hFB, 1'b1);
      irq_in[2] = 1'b1;
      idle(5);
      access(0, 32'h04, 1'b1);
      access(0, 32'd0, 1'b0);
      irq_in[2] = 1'b0;
      idle(S + 1);
      access(0, 32'h04, 1'b1);
      access(0, 32'd0, 1'b0);
      chk_any("level_clr");
      access(2, 32'hFF, 1'b1);

      // W1C landing on the same edge as the set of bit 0
      irq_in[0] = 1'b1;
      tick();
      tick();
      access(0, 32'h01, 1'b1);
      access(0, 32'd0, 1'b0);
      irq_in[0] = 1'b0;
      idle(4);

      // reset during a read
      idle(2);
      bus.start = 1'b1; bus.addr = AB'(0); bus.we = 1'b0;
      reset = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.q !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_access done %b q %h want 0 0", bus.done, bus.q);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_access_after done %b want 0", bus.done);
      end
      access(1, 32'd0, 1'b0);

      // counter saturation on channel 4
      for (int k = 0; k < 300; k++) begin
         irq_in[4] = 1'b1; idle(2);
         irq_in[4] = 1'b0; idle(2);
      end
      idle(4);
      access(5, 32'h04, 1'b1);
      access(5, 32'd0, 1'b0);
      access(5, 32'h8000_0000, 1'b1);
      access(5, 32'd0, 1'b0);
      access(5, 32'h04, 1'b1);
      access(5, 32'd0, 1'b0);
      access(0, 32'hFF, 1'b1);

      // randomized traffic
      for (int c = 0; c < 2500; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
         if ($urandom_range(0, 2) == 0) begin
            bus.start = 1'b1;
            bus.addr  = AB'($urandom_range(0, 7));
            bus.we    = ($urandom_range(0, 2) == 0);
            bus.data  = $urandom;
         end else begin
            bus.start = 1'b0;
            bus.we    = 1'b0;
         end
         tick();
         if (c % 97 == 0) chk_any("random");
      end
      bus.start = 1'b0; bus.we = 1'b0;
      idle(10);

      checks++;
      if (rd_q.size() != 0) begin
         errors++;
         $display("FAIL read_queue_left %0d want 0", rd_q.size());
      end
      checks++;
      if (cpu_q.size() != 0) begin
         errors++;
         $display("FAIL cpu_queue_left %0d want 0", cpu_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
